// File: rtl/mem_pkg.sv
// Shared opcodes, load/store width encodings and FSM states for the memory-access stage.
package mem_pkg;

  localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
  localparam logic [6:0]  OPC_STORE = 7'b0100011;
  localparam logic [31:0] NOP_INST  = 32'h00000013;

  typedef enum logic [2:0] {
    LS_LB  = 3'b000,
    LS_LH  = 3'b001,
    LS_LW  = 3'b010,
    LS_LBU = 3'b100,
    LS_LHU = 3'b101
  } ls_width_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } acc_size_e;

  // Reserved funct3 codes fall back to a full-word access for both loads and stores.
  function automatic acc_size_e acc_size(input logic is_store, input logic [2:0] funct3);
    acc_size_e sz;
    sz = SZ_WORD;
    if (is_store) begin
      if (funct3 == 3'b000)      sz = SZ_BYTE;
      else if (funct3 == 3'b001) sz = SZ_HALF;
    end else begin
      if (funct3[1:0] == 2'b00)      sz = SZ_BYTE;
      else if (funct3[1:0] == 2'b01) sz = SZ_HALF;
    end
    return sz;
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Combinational load aligner: selects the addressed byte/half of a read word and extends it.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    unique case (addr_lo)
      2'b00:   byte_sel = rdata[7:0];
      2'b01:   byte_sel = rdata[15:8];
      2'b10:   byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      LS_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      LS_LH:   result = {{16{half_sel[15]}}, half_sel};
      LS_LBU:  result = {24'h000000, byte_sel};
      LS_LHU:  result = {16'h0000, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: req/ack data-memory transaction, load alignment, write-back register.
// Optional build macro MEM_MISALIGN_TRAP_EN traps misaligned half/word accesses without a bus request.
module mem_access
  import mem_pkg::*;
#(
  parameter int ACK_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_inst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] exe_result,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  output logic        mem_stall,
  output logic [31:0] mem_result,
  output logic [31:0] wb_inst,
  output logic        bus_err,
  output logic        misalign
);

  localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

  mem_state_e  state_q;
  logic [7:0]  cnt_q;
  logic [31:0] rdata_q, addr_q, wdata_q, result_q, wb_inst_q;
  logic [3:0]  be_q;
  logic [1:0]  addr_lo_q;
  logic [2:0]  funct3_q;
  logic        we_q, bus_err_q, trap_q;

  logic [2:0]  funct3;
  logic        is_load, is_store, is_mem, trap_d;
  acc_size_e   size;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, load_data;

  assign funct3   = mem_inst[14:12];
  assign is_load  = (mem_inst[6:0] == OPC_LOAD);
  assign is_store = (mem_inst[6:0] == OPC_STORE);
  assign is_mem   = is_load || is_store;
  assign size     = acc_size(is_store, funct3);

  // Store lanes are replicated so the memory only needs to honour the byte enables.
  always_comb begin
    be_d    = 4'b0000;
    wdata_d = '0;
    if (is_store) begin
      unique case (size)
        SZ_BYTE: begin
          be_d    = 4'b0001 << mem_addr[1:0];
          wdata_d = {4{exe_result[7:0]}};
        end
        SZ_HALF: begin
          be_d    = 4'b0011 << {mem_addr[1], 1'b0};
          wdata_d = {2{exe_result[15:0]}};
        end
        default: begin
          be_d    = 4'b1111;
          wdata_d = exe_result;
        end
      endcase
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap_d   = is_mem && ((size == SZ_HALF && mem_addr[0]) ||
                               (size == SZ_WORD && mem_addr[1:0] != 2'b00));
  assign misalign = (state_q == ST_DONE) && trap_q;
`else
  assign trap_d   = 1'b0;
  assign misalign = 1'b0;
`endif

  // Stall is gated by rst so an abandoned access releases the pipeline without a clock edge.
  assign mem_stall  = !rst && ((state_q == ST_IDLE && is_mem) || state_q == ST_BUSY);
  assign dmem_req   = (state_q == ST_BUSY);
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_be    = be_q;
  assign mem_result = result_q;
  assign wb_inst    = wb_inst_q;
  assign bus_err    = bus_err_q;

  load_align u_load_align (
    .rdata   (rdata_q),
    .addr_lo (addr_lo_q),
    .funct3  (funct3_q),
    .result  (load_data)
  );

  // NOTE: every register here uses non-blocking assignment so all branches see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rdata_q   <= '0;
      addr_q    <= '0;
      addr_lo_q <= '0;
      funct3_q  <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      we_q      <= 1'b0;
      trap_q    <= 1'b0;
      bus_err_q <= 1'b0;
      result_q  <= '0;
      wb_inst_q <= NOP_INST;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (is_mem) begin
            cnt_q <= '0;
            if (trap_d) begin
              trap_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              addr_q    <= {mem_addr[31:2], 2'b00};
              addr_lo_q <= mem_addr[1:0];
              funct3_q  <= funct3;
              we_q      <= is_store;
              be_q      <= be_d;
              wdata_q   <= wdata_d;
              state_q   <= ST_BUSY;
            end
          end else begin
            result_q  <= exe_result;
            wb_inst_q <= mem_inst;
          end
        end
        ST_BUSY: begin
          if (dmem_ack) begin
            rdata_q <= dmem_rdata;
            state_q <= ST_DONE;
          end else if (cnt_q == CNT_LAST) begin
            rdata_q   <= '0;
            bus_err_q <= 1'b1;
            state_q   <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_DONE: begin
          if (trap_q) begin
            result_q  <= '0;
            wb_inst_q <= NOP_INST;
          end else begin
            result_q  <= we_q ? '0 : load_data;
            wb_inst_q <= mem_inst;
          end
          trap_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access pipeline stage, directly downstream of the execute stage. Consumes the registered instruction, effective address and result/store-data from execute, runs a req/ack transaction on the data-memory port for loads and stores, aligns and extends load data, and registers the write-back value. Drives the pipeline-wide stall that holds execute and earlier stages while a transaction is outstanding.

## Interface
- ACK_TIMEOUT, 64: BUSY cycles without `dmem_ack` before the access is abandoned; range 1..255.
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- mem_inst  in  32  instruction from execute.
- mem_addr  in  32  effective address (loads/stores), else don't-care.
- exe_result  in  32  ALU result, or rs2 store data for stores.
- dmem_ack  in  1  memory completes current request this cycle.
- dmem_rdata  in  32  read word; valid when `dmem_ack`=1 on a read.
- dmem_req  out  1  request valid.
- dmem_we  out  1  1=store, 0=load.
- dmem_addr  out  32  word address, `{mem_addr[31:2],2'b00}`.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables (stores); 4'b0000 on loads.
- mem_stall  out  1  freeze request to all earlier stages.
- mem_result  out  32  registered write-back value.
- wb_inst  out  32  registered instruction to write-back.
- bus_err  out  1  sticky: a timeout has occurred.
- misalign  out  1  one-cycle pulse on a trapped misaligned access (macro only).

## Operation
- Memory op: opcode 7'b0000011 (LOAD) or 7'b0100011 (STORE). All other opcodes are pass-through.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE with a pass-through instruction: `mem_result`<=`exe_result`, `wb_inst`<=`mem_inst`, `mem_stall`=0.
- IDLE with a memory op: `mem_stall`=1 (combinational). Next state is BUSY. Address, write data and byte enables are latched.
- BUSY: `dmem_req`=1 and `mem_stall`=1. Outputs are held stable from the latched copies.
  - On `dmem_ack`: capture `dmem_rdata`, go to DONE.
  - On timeout: go to DONE with a zero load buffer and set `bus_err`.
- DONE: `mem_stall`=0.
  - Loads: `mem_result`<=aligned load data.
  - Stores: `mem_result`<=0.
  - Both: `wb_inst`<=`mem_inst`. Next state is IDLE.
- Load funct3 encodings:
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - Reserved 011/110/111 are treated as LW.
- Byte select is `addr[1:0]`. Half select is `addr[1]`.
- Store encodings:
  - SB: `be`=4'b0001<<`addr[1:0]`, data = byte replicated ×4.
  - SH: `be`=4'b0011<<{`addr[1]`,0}, data = half replicated ×2.
  - SW and reserved encodings: `be`=4'b1111.
- Timeout counter is 8 bits. It clears on entry to BUSY and increments each BUSY cycle without ack. Timeout fires when the count reaches ACK_TIMEOUT-1 with no ack.
- `dmem_ack` outside BUSY is ignored.
- `bus_err` clears only on `rst`.

## Timing
- Reset (async, immediate) drives all outputs as follows:
  - state=IDLE, `dmem_req`=0, `mem_stall`=0.
  - `mem_result`=0, `wb_inst`=32'h00000013 (NOP).
  - `bus_err`=0, `misalign`=0, counter=0.
  - `dmem_addr`/`dmem_wdata`/`dmem_be`/`dmem_we` = 0.
- Pass-through latency: 1 cycle, no stall.
- Memory op with ack in first BUSY cycle: 3 cycles.
  - c0 IDLE, stall=1.
  - c1 BUSY, req=1, ack=1.
  - c2 DONE, stall=0. Result is registered at the end of c2.
- Each extra wait cycle adds one cycle.
- Back-to-back memory ops: the second op's IDLE cycle immediately follows DONE.
- `dmem_req` deasserts in the cycle after the ack cycle.
- `rst` mid-BUSY drops `dmem_req` asynchronously and discards the transaction. The memory side must tolerate the abandoned request.
- `mem_inst`, `mem_addr` and `exe_result` must be stable while `mem_stall`=1. Execute guarantees this through freeze.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined: a misaligned access (LH/LHU/SH with `addr[0]`=1, or LW/SW with `addr[1:0]`≠0) behaves as follows:
  - It never enters BUSY and issues no request.
  - IDLE goes directly to DONE (stall=1 for one cycle).
  - In DONE: `misalign`=1, `mem_result`<=0, `wb_inst`<=NOP.
- Undefined: `misalign` is tied to 0 and misalignment is not checked.
  - Half accesses ignore `addr[0]`.
  - Word accesses ignore `addr[1:0]`.

## Structure
- Package `mem_pkg` holds:
  - `OPC_LOAD` and `OPC_STORE`.
  - A funct3 enum `ls_width_e` (LB, LH, LW, LBU, LHU).
  - `NOP_INST`=32'h00000013.
  - FSM enum `mem_state_e`.
- Sub-module `load_align` is combinational. It takes (`rdata`, `addr[1:0]`, `funct3`) and returns the 32-bit extended result; it is instantiated once.
- Store lane/enable generation stays inline.

## Test plan
- ADDI pass-through with `exe_result`=32'h0000_1234 → `mem_result`=32'h1234 and `wb_inst` match next edge; `mem_stall` never high.
- LB at `mem_addr`=32'h103, `dmem_rdata`=32'h80FF_7F01, ack in first BUSY → `dmem_addr`=32'h100, `mem_result`=32'hFFFF_FF80 after 3 cycles. The same case as LBU → 32'h0000_0080.
- SH at `mem_addr`=32'h202 with `exe_result`=32'hAAAA_BEEF → `dmem_be`=4'b1100, `dmem_wdata`=32'hBEEF_BEEF, `dmem_we`=1; ack after 4 wait cycles → stall held for 6 cycles total.
- No ack, ACK_TIMEOUT=4 → 4 BUSY cycles, then DONE with `mem_result`=0; `bus_err`=1 and stays 1 until `rst`.
- `rst` asserted in BUSY → `dmem_req` and `mem_stall` fall without a clock edge; a later ack is ignored; `wb_inst`=32'h13.
- Macro defined, LW at 32'h101 → no `dmem_req`, `misalign` pulse, `wb_inst`=NOP. Macro undefined → LW at 32'h101 issues `dmem_addr`=32'h100.
